dm_cache_tag_data_store: RTL and testbench

- Storage back-end of the direct-mapped, write-back cache: a 1024-entry tag array and a 1024-line × 128-bit data array.
- Includes a debug tag-view tap that exposes the tag field of the current CPU address.
- Sits under the cache controller FSM, which drives index/write-enable/write-data each cycle and consumes the combinational read results.
- Holds no policy; all hit/miss/allocate/write-back decisions live in the FSM.

---
 rtl/cache_def.sv | 47 ++++
 rtl/cache_data_array.sv | 26 ++
 rtl/cache_tag_array.sv | 27 ++
 rtl/dm_cache_tag_data_store.sv | 39 +++
 tb/tb_dm_cache_tag_data_store.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_def.sv
// rtl/cache_def.sv - shared types and geometry for the direct-mapped write-back cache
package cache_def;

  localparam int TAGMSB     = 31;
  localparam int TAGLSB     = 14;
  localparam int INDEX_BITS = 10;
  localparam int LINE_BITS  = 128;
  localparam int DEPTH      = 1 << INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic                  we;
    logic [INDEX_BITS-1:0] index;
  } cache_req_type;

  typedef logic [LINE_BITS-1:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - line storage with combinational read and synchronous write
module cache_data_array
  import cache_def::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  cache_req_type  i_req,
  input  cache_data_type i_wdata,
  output cache_data_type o_rdata
);

  cache_data_type r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_req.we) begin
      r_mem[i_req.index] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_req.index];

endmodule

// File: rtl/cache_tag_array.sv
// rtl/cache_tag_array.sv - tag storage with combinational read and synchronous write
module cache_tag_array
  import cache_def::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  cache_req_type i_req,
  input  cache_tag_type i_wdata,
  output cache_tag_type o_rdata
);

  cache_tag_type r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_req.we) begin
      r_mem[i_req.index] <= i_wdata;
    end
  end

  // No bypass: a same-index write becomes visible only after the edge.
  assign o_rdata = r_mem[i_req.index];

endmodule

// File: rtl/dm_cache_tag_data_store.sv
// rtl/dm_cache_tag_data_store.sv - tag and data arrays under the cache FSM, plus debug tag view
module dm_cache_tag_data_store
  import cache_def::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  cache_req_type        tag_req,
  input  cache_tag_type        tag_write,
  output cache_tag_type        tag_read,
  input  cache_req_type        data_req,
  input  cache_data_type       data_write,
  output cache_data_type       data_read,
  input  logic [31:0]          cpu_req_addr,
  output logic [TAGMSB:TAGLSB] cpu_req_tag
);

  logic w_unused_addr;

  cache_tag_array u_tag_array (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_req   (tag_req),
    .i_wdata (tag_write),
    .o_rdata (tag_read)
  );

  cache_data_array u_data_array (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_req   (data_req),
    .i_wdata (data_write),
    .o_rdata (data_read)
  );

  // Waveform-only view of the tag field; independent of reset.
  assign cpu_req_tag   = cpu_req_addr[TAGMSB:TAGLSB];
  assign w_unused_addr = ^cpu_req_addr[TAGLSB-1:0];

endmodule

// File: tb/tb_dm_cache_tag_data_store.sv
// tb/tb_dm_cache_tag_data_store.sv - scoreboard bench for the cache tag/data store
module tb_dm_cache_tag_data_store;
  import cache_def::*;

  logic           clk;
  logic           clk_run;
  logic           rst;
  cache_req_type  tag_req;
  cache_tag_type  tag_write;
  cache_tag_type  tag_read;
  cache_req_type  data_req;
  cache_data_type data_write;
  cache_data_type data_read;
  logic [31:0]    cpu_req_addr;
  logic [17:0]    cpu_req_tag;

  int n_checks = 0;
  int n_pass   = 0;

  string        q_name [$];
  logic [127:0] q_exp  [$];

  localparam logic [127:0] D_HI = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D_LO = 128'hFFFFFFFFFFFFFFFF0000000000000000;
  localparam logic [127:0] D_A  = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [127:0] D_B  = 128'h0000FFFF_1111EEEE_2222DDDD_3333CCCC;
  localparam logic [127:0] D_3  = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] D_9  = 128'h99999999_99999999_99999999_99999999;

  dm_cache_tag_data_store dut (
    .clk          (clk),
    .rst          (rst),
    .tag_req      (tag_req),
    .tag_write    (tag_write),
    .tag_read     (tag_read),
    .data_req     (data_req),
    .data_write   (data_write),
    .data_read    (data_read),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_tag  (cpu_req_tag)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, obs, exp);
  endtask

  task automatic sb_push(input string name, input logic [127:0] exp);
    q_name.push_back(name);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [127:0] obs);
    if (q_exp.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: got output %h expected a pending entry", obs);
    end else begin
      check_val(q_name.pop_front(), obs, q_exp.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_tag(input logic [9:0] idx);
    tag_req.index = idx;
    #1;
    sb_pop(128'(tag_read));
  endtask

  task automatic rd_data(input logic [9:0] idx);
    data_req.index = idx;
    #1;
    sb_pop(data_read);
  endtask

  initial begin
    logic [9:0] idx_list [3];
    idx_list[0] = 10'd0;
    idx_list[1] = 10'd5;
    idx_list[2] = 10'd1023;
    clk_run      = 1'b0;
    tag_req      = '0;
    data_req     = '0;
    tag_write    = '0;
    data_write   = '0;
    cpu_req_addr = '0;
    rst          = 1'b1;
    #2 rst = 1'b0;
    #2;

    // Asynchronous reset, no clock running yet
    foreach (idx_list[i]) begin
      sb_push($sformatf("rst_tag_%0d", idx_list[i]), 128'd0);
      rd_tag(idx_list[i]);
      sb_push($sformatf("rst_data_%0d", idx_list[i]), 128'd0);
      rd_data(idx_list[i]);
    end

    // Writes held off while reset is asserted
    clk_run    = 1'b1;
    tag_req    = {1'b1, 10'd5};
    tag_write  = {1'b1, 1'b1, 18'h2A};
    data_req   = {1'b1, 10'd5};
    data_write = '1;
    tick();
    tick();
    tag_req.we  = 1'b0;
    data_req.we = 1'b0;
    sb_push("rst_hold_tag", 128'd0);
    rd_tag(10'd5);
    sb_push("rst_hold_data", 128'd0);
    rd_data(10'd5);

    rst       = 1'b1;
    tag_req   = {1'b1, 10'd5};
    tag_write = {1'b1, 1'b1, 18'h2A};
    sb_push("tag_wr_5", 128'h C002A);
    tick();
    tag_req.we = 1'b0;
    rd_tag(10'd5);
    sb_push("tag_nb_4", 128'd0);
    rd_tag(10'd4);
    sb_push("tag_nb_6", 128'd0);
    rd_tag(10'd6);

    data_req   = {1'b1, 10'd1023};
    data_write = D_HI;
    tick();
    data_req   = {1'b1, 10'd0};
    data_write = D_LO;
    tick();
    data_req.we = 1'b0;
    sb_push("data_1023", D_HI);
    rd_data(10'd1023);
    sb_push("data_0", D_LO);
    rd_data(10'd0);

    // Read-during-write, data then tag
    data_req   = {1'b1, 10'd7};
    data_write = D_A;
    tick();
    data_write = D_B;
    sb_push("rdw_data_old", D_A);
    sb_push("rdw_data_new", D_B);
    #1 sb_pop(data_read);
    tick();
    sb_pop(data_read);
    data_req.we = 1'b0;

    tag_req   = {1'b1, 10'd7};
    tag_write = {1'b1, 1'b0, 18'h11};
    tick();
    tag_write = {1'b1, 1'b1, 18'h3FFFF};
    sb_push("rdw_tag_old", 128'h80011);
    sb_push("rdw_tag_new", 128'hFFFFF);
    #1 sb_pop(128'(tag_read));
    tick();
    sb_pop(128'(tag_read));
    tag_req.we = 1'b0;

    // Independent ports at different indices
    tag_req    = {1'b1, 10'd9};
    tag_write  = {1'b1, 1'b0, 18'h99};
    data_req   = {1'b1, 10'd3};
    data_write = D_3;
    tick();
    tag_req    = {1'b1, 10'd3};
    tag_write  = {1'b0, 1'b1, 18'h33};
    data_req   = {1'b1, 10'd9};
    data_write = D_9;
    tick();
    tag_req.we  = 1'b0;
    data_req.we = 1'b0;
    sb_push("ind_tag_3", 128'h40033);
    rd_tag(10'd3);
    sb_push("ind_data_9", D_9);
    rd_data(10'd9);
    sb_push("ind_tag_9", 128'h80099);
    rd_tag(10'd9);
    sb_push("ind_data_3", D_3);
    rd_data(10'd3);

    // Debug tag view
    cpu_req_addr = 32'h0001_4010;
    sb_push("dbg_tag_a", 128'h5);
    #1 sb_pop(128'(cpu_req_tag));
    cpu_req_addr = 32'hFFFF_C000;
    sb_push("dbg_tag_b", 128'h3FFFF);
    #1 sb_pop(128'(cpu_req_tag));
    cpu_req_addr = 32'h0000_3FFF;
    sb_push("dbg_tag_c", 128'h0);
    #1 sb_pop(128'(cpu_req_tag));

    // Mid-operation async reset discards the pending write
    tick();
    tag_req    = {1'b1, 10'd5};
    tag_write  = {1'b1, 1'b1, 18'h1234};
    data_req   = {1'b1, 10'd1023};
    data_write = D_B;
    rst        = 1'b0;
    sb_push("arst_valid", 128'd0);
    sb_push("arst_data", 128'd0);
    #1 sb_pop(128'(tag_read.valid));
    sb_pop(data_read);
    tick();
    sb_push("arst_tag_edge", 128'd0);
    sb_push("arst_data_edge", 128'd0);
    sb_pop(128'(tag_read));
    sb_pop(data_read);
    rst         = 1'b1;
    tag_req.we  = 1'b0;
    data_req.we = 1'b0;

    if (q_exp.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover: got %0d pending expected 0", q_exp.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
